// File: rtl/top_level.sv
// Accumulator CPU: loadable program memory, 16-entry register file,
// single-cycle execute with debug taps on architectural state.
module top_level #(
  parameter int SIZE      = 8,
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 W,
  input  logic                 OVERWRITE,
  input  logic [ADDR_SIZE-1:0] ADDR,
  input  logic [DATA_SIZE-1:0] DATA_WR,
  output logic [ADDR_SIZE-1:0] PC_OUT,
  output logic [SIZE-1:0]      ACC_OUT,
  output logic                 C_FLAG,
  output logic                 Z_FLAG,
  output logic                 HALT
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [SIZE:0] ALU_ONE = (SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PC_ONE = ADDR_SIZE'(1);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_NOT = 4'd8,
    OP_ST  = 4'd9,
    OP_JMP = 4'd10,
    OP_HLT = 4'd15
  } op_e;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [SIZE-1:0]      r_rf  [16];
  logic [ADDR_SIZE-1:0] r_pc;
  logic [SIZE-1:0]      r_acc;
  logic                 r_c;
  logic                 r_z;
  logic                 r_halt;

  logic [DATA_SIZE-1:0] w_ins;
  op_e                  w_op;
  logic [3:0]           w_mop;
  logic [3:0]           w_l;
  logic [3:0]           w_r;
  logic [SIZE-1:0]      w_a;
  logic [SIZE-1:0]      w_b;
  logic [SIZE:0]        w_alu;
  logic                 w_alu_en;
  logic                 w_rf_we;
  logic [SIZE-1:0]      w_rf_wd;
  logic                 w_jmp;
  logic                 w_hlt;
  logic [ADDR_SIZE-1:0] w_jt;
  logic                 w_run;

  assign w_ins = r_mem[r_pc];
  assign w_op  = op_e'(w_ins[15:12]);
  assign w_mop = w_ins[11:8];
  assign w_l   = w_ins[7:4];
  assign w_r   = w_ins[3:0];
  assign w_a   = r_rf[w_l];
  assign w_b   = r_rf[w_r];
  assign w_jt  = ADDR_SIZE'({w_l, w_r});
  assign w_run = !W && !r_halt;

  // Bit SIZE of w_alu is the carry, or the borrow for subtraction.
  always_comb begin
    w_alu    = '0;
    w_alu_en = 1'b0;
    w_rf_we  = 1'b0;
    w_rf_wd  = '0;
    w_jmp    = 1'b0;
    w_hlt    = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a} + {1'b0, w_b};
      end
      OP_SUB: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a} - {1'b0, w_b};
      end
      OP_AND: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a & w_b};
      end
      OP_OR: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a | w_b};
      end
      OP_XOR: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a ^ w_b};
      end
      OP_INC: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a} + ALU_ONE;
      end
      OP_DEC: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, w_a} - ALU_ONE;
      end
      OP_NOT: begin
        w_alu_en = 1'b1;
        w_alu    = {1'b0, ~w_a};
      end
      OP_ST: begin
        case (w_mop)
          4'd0: begin
            w_rf_we = 1'b1;
            w_rf_wd = w_b;
          end
          4'd1: begin
            w_rf_we = 1'b1;
            w_rf_wd = r_acc;
          end
          4'd2: begin
            w_rf_we = 1'b1;
            w_rf_wd = SIZE'(w_r);
          end
          default: ;
        endcase
      end
      OP_JMP: w_jmp = 1'b1;
      OP_HLT: w_hlt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (W && OVERWRITE) begin
      r_mem[ADDR] <= DATA_WR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (w_run && w_rf_we) begin
      r_rf[w_l] <= w_rf_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc   <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      r_halt <= 1'b0;
    end else if (W) begin
      r_pc   <= '0;
      r_halt <= 1'b0;
    end else if (!r_halt) begin
      if (w_alu_en) begin
        r_acc <= w_alu[SIZE-1:0];
        r_c   <= w_alu[SIZE];
        r_z   <= (w_alu[SIZE-1:0] == '0);
      end
      if (w_hlt)
        r_halt <= 1'b1;
      else if (w_jmp)
        r_pc <= w_jt;
      else
        r_pc <= r_pc + PC_ONE;
    end
  end

  assign PC_OUT  = r_pc;
  assign ACC_OUT = r_acc;
  assign C_FLAG  = r_c;
  assign Z_FLAG  = r_z;
  assign HALT    = r_halt;

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: integer-level architectural model compared every
// cycle, plus directed programs with hand-computed expectations.
module tb_top_level;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        W = 1'b1;
  logic        OVERWRITE = 1'b0;
  logic [4:0]  ADDR = '0;
  logic [15:0] DATA_WR = '0;
  logic [4:0]  PC_OUT;
  logic [7:0]  ACC_OUT;
  logic        C_FLAG;
  logic        Z_FLAG;
  logic        HALT;

  int checks = 0;
  int failures = 0;

  top_level #(.SIZE(8), .DATA_SIZE(16), .ADDR_SIZE(5)) dut (
    .clk(clk), .rstn(rstn), .W(W), .OVERWRITE(OVERWRITE),
    .ADDR(ADDR), .DATA_WR(DATA_WR), .PC_OUT(PC_OUT),
    .ACC_OUT(ACC_OUT), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .HALT(HALT)
  );

  always #5 clk = ~clk;

  // Architectural model in plain integers.
  int m_mem [32];
  int m_r [16];
  int m_acc = 0;
  int m_pc = 0;
  int m_c = 0;
  int m_z = 0;
  int m_h = 0;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_acc = 0; m_pc = 0; m_c = 0; m_z = 0; m_h = 0;
  endtask

  task automatic m_step();
    int ins, op, mop, l, r, a, b, res, nxt;
    bit alu;
    if (W) begin
      if (OVERWRITE) m_mem[ADDR] = DATA_WR;
      m_pc = 0;
      m_h = 0;
    end else if (m_h == 0) begin
      ins = m_mem[m_pc];
      op = ins / 4096;
      mop = (ins / 256) % 16;
      l = (ins / 16) % 16;
      r = ins % 16;
      a = m_r[l];
      b = m_r[r];
      nxt = (m_pc + 1) % 32;
      alu = 1;
      res = 0;
      case (op)
        1: begin res = a + b; m_c = (res > 255); end
        2: begin res = a - b; m_c = (a < b); end
        3: begin res = a & b; m_c = 0; end
        4: begin res = a | b; m_c = 0; end
        5: begin res = a ^ b; m_c = 0; end
        6: begin res = a + 1; m_c = (res > 255); end
        7: begin res = a - 1; m_c = (a == 0); end
        8: begin res = 255 - a; m_c = 0; end
        default: alu = 0;
      endcase
      if (op == 9) begin
        if (mop == 0) m_r[l] = b;
        else if (mop == 1) m_r[l] = m_acc;
        else if (mop == 2) m_r[l] = r;
      end
      if (op == 10) nxt = (ins % 256) % 32;
      if (op == 15) begin m_h = 1; nxt = m_pc; end
      if (alu) begin
        m_acc = ((res % 256) + 256) % 256;
        m_z = (m_acc == 0);
      end
      m_pc = nxt;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else m_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_pc", int'(PC_OUT), m_pc);
      chk("cyc_acc", int'(ACC_OUT), m_acc);
      chk("cyc_c", int'(C_FLAG), m_c);
      chk("cyc_z", int'(Z_FLAG), m_z);
      chk("cyc_halt", int'(HALT), m_h);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
  endtask

  task automatic load(input int a, input int d);
    @(negedge clk);
    W = 1'b1;
    OVERWRITE = 1'b1;
    ADDR = 5'(a);
    DATA_WR = 16'(d);
  endtask

  task automatic go();
    @(negedge clk);
    W = 1'b0;
    OVERWRITE = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_state(input string name, input int pc, input int acc,
                           input int c, input int z, input int h);
    chk({name, "_pc"}, int'(PC_OUT), pc);
    chk({name, "_acc"}, int'(ACC_OUT), acc);
    chk({name, "_c"}, int'(C_FLAG), c);
    chk({name, "_z"}, int'(Z_FLAG), z);
    chk({name, "_halt"}, int'(HALT), h);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #3 chk_state("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    started = 1;

    // INC / ADD to zero / register move
    load(0, 16'h6012);
    load(1, 16'h1023);
    load(2, 16'h9010);
    go();
    run(1);
    chk("t1_acc0", int'(ACC_OUT), 1);
    chk("t1_z0", int'(Z_FLAG), 0);
    run(1);
    chk("t1_acc1", int'(ACC_OUT), 0);
    chk("t1_z1", int'(Z_FLAG), 1);
    run(1);
    chk("t1_pc", int'(PC_OUT), 3);

    // immediates and doubling with final carry
    do_reset();
    load(0, 16'h921F);
    load(1, 16'h922F);
    load(2, 16'h1012);
    for (int i = 0; i < 4; i++) begin
      load(3 + 2 * i, 16'h9130);
      load(4 + 2 * i, 16'h1033);
    end
    go();
    run(3);
    chk("t2_1e", int'(ACC_OUT), 8'h1E);
    run(2);
    chk("t2_3c", int'(ACC_OUT), 8'h3C);
    run(2);
    chk("t2_78", int'(ACC_OUT), 8'h78);
    run(2);
    chk("t2_f0", int'(ACC_OUT), 8'hF0);
    chk("t2_c0", int'(C_FLAG), 0);
    run(2);
    chk("t2_e0", int'(ACC_OUT), 8'hE0);
    chk("t2_c1", int'(C_FLAG), 1);

    // subtract with and without borrow
    do_reset();
    load(0, 16'h9213);
    load(1, 16'h9225);
    load(2, 16'h2012);
    load(3, 16'h2022);
    go();
    run(3);
    chk_state("t3a", 3, 8'hFE, 1, 0, 0);
    run(1);
    chk_state("t3b", 4, 0, 0, 1, 0);

    // jump then halt
    do_reset();
    load(0, 16'hA004);
    load(4, 16'hF000);
    go();
    run(1);
    chk("t4_jpc", int'(PC_OUT), 4);
    chk("t4_jh", int'(HALT), 0);
    run(1);
    chk("t4_h", int'(HALT), 1);
    run(10);
    chk("t4_hpc", int'(PC_OUT), 4);
    chk("t4_hh", int'(HALT), 1);
    @(negedge clk);
    W = 1'b1;
    run(1);
    chk("t4_wpc", int'(PC_OUT), 0);
    chk("t4_wh", int'(HALT), 0);

    // PC wrap over empty memory and load gating
    do_reset();
    go();
    run(31);
    chk("t5_pc31", int'(PC_OUT), 31);
    run(1);
    chk_state("t5_wrap", 0, 0, 0, 0, 0);
    @(negedge clk);
    OVERWRITE = 1'b1;
    ADDR = 5'd0;
    DATA_WR = 16'h6000;
    run(1);
    OVERWRITE = 1'b0;
    run(40);
    chk("t5_nowr_acc", int'(ACC_OUT), 0);
    @(negedge clk);
    W = 1'b1;
    OVERWRITE = 1'b0;
    run(3);
    chk("t5_held_pc", int'(PC_OUT), 0);
    go();
    run(1);
    chk("t5_noov_acc", int'(ACC_OUT), 0);
    chk("t5_noov_pc", int'(PC_OUT), 1);

    // asynchronous reset in the middle of a run
    load(0, 16'h6000);
    go();
    run(1);
    chk("t6_acc1", int'(ACC_OUT), 1);
    #2 rstn = 1'b0;
    #1 chk_state("t6_async", 0, 0, 0, 0, 0);
    #1 rstn = 1'b1;
    run(1);
    chk("t6_nop_acc", int'(ACC_OUT), 0);
    chk("t6_nop_pc", int'(PC_OUT), 1);

    run(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
